mac_rx_bank_ctrl: RTL and testbench

- Controls the MAC receive path into a two-bank (ping-pong) packet buffer.
- Runs the MAC read-request handshake and allocates a free bank per packet.
- Generates the buffer write strobe, bank select and address.
- Drops packets when no bank is free or a packet overflows a bank; banks are returned by the reader through release pulses.

---
 rtl/mac_rx_bank_ctrl.sv | 139 +++++++++++++
 tb/tb_mac_rx_bank_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_bank_ctrl.sv
// MAC receive to ping-pong buffer writer: allocates a free bank per packet, drops on no-bank/overflow.
// Write strobe/address combinational with the MAC word; read request registered; no backpressure beyond bank availability.
module mac_rx_bank_ctrl #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 32
) (
  input  logic              mac_clk_i,
  input  logic              ARESETN,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  input  logic [1:0]        rel_i,
  output logic [1:0]        bank_full_o,
  output logic [ADDR_W:0]   bank_len0_o,
  output logic [ADDR_W:0]   bank_len1_o,
  output logic [CNT_W-1:0]  pkt_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_DRAIN, S_COMMIT} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            r_state;
  logic              r_sop_seen;
  logic              r_last_bank;
  logic              r_bank;
  logic              r_rqrd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_full;
  logic [ADDR_W:0]   r_len0;
  logic [ADDR_W:0]   r_len1;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_in_wr;
  logic              w_sop;
  logic              w_eop;
  logic              w_wr_en;
  logic              w_ovf;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_len;

  assign w_in_wr = (r_state == S_WR);
  assign w_sop   = mac_rxdv_i & mac_rxsop_i;
  assign w_eop   = mac_rxdv_i & mac_rxeop_i;
  assign w_wr_en = w_in_wr & (r_sop_seen | w_sop) & mac_rxdv_i;
  // A start-of-packet always lands at word 0, even when it restarts a partial packet.
  assign w_addr  = (w_in_wr & w_sop) ? '0 : r_addr;
  assign w_ovf   = w_wr_en & ~mac_rxeop_i & (w_addr == ADDR_MAX);
  assign w_len   = {1'b0, w_addr} + (ADDR_W + 1)'(1);

  assign mac_rxrqrd_o = r_rqrd;
  assign wr_en_o      = w_wr_en;
  assign wr_bank_o    = r_bank;
  assign wr_addr_o    = w_addr;
  assign bank_full_o  = r_full;
  assign bank_len0_o  = r_len0;
  assign bank_len1_o  = r_len1;
  assign pkt_cnt_o    = r_pkt_cnt;
  assign drop_cnt_o   = r_drop_cnt;
  assign ovf_o        = w_ovf;

  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_sop_seen  <= 1'b0;
      r_last_bank <= 1'b1;
      r_bank      <= 1'b0;
      r_rqrd      <= 1'b0;
      r_addr      <= '0;
      r_full      <= 2'b00;
      r_len0      <= '0;
      r_len1      <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // Releases apply in every state; a commit in the same cycle overrides below.
      r_full <= r_full & ~rel_i;
      case (r_state)
        S_IDLE: begin
          r_rqrd <= 1'b0;
          if (mac_rxda_i) begin
            r_rqrd     <= 1'b1;
            r_addr     <= '0;
            r_sop_seen <= 1'b0;
            if (!r_full[~r_last_bank]) begin
              r_bank  <= ~r_last_bank;
              r_state <= S_WR;
            end else if (!r_full[r_last_bank]) begin
              r_bank  <= r_last_bank;
              r_state <= S_WR;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_WR: begin
          r_rqrd <= mac_rxda_i;
          if (w_sop) r_sop_seen <= 1'b1;
          if (w_wr_en) begin
            if (w_eop) begin
              if (r_bank) r_len1 <= w_len;
              else        r_len0 <= w_len;
              r_state <= S_COMMIT;
            end else if (w_ovf) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= w_addr + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          r_rqrd <= mac_rxda_i;
          if (w_eop) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            r_rqrd     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_COMMIT: begin
          r_full[r_bank] <= 1'b1;
          r_pkt_cnt      <= r_pkt_cnt + CNT_W'(1);
          r_last_bank    <= r_bank;
          r_rqrd         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_bank_ctrl.sv
// Randomized bench for mac_rx_bank_ctrl with a packet-level reference model and a write scoreboard.
module tb_mac_rx_bank_ctrl;
  localparam int AW   = 3;
  localparam int CW   = 32;
  localparam int MAXA = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          rxda = 1'b0, rxsop = 1'b0, rxeop = 1'b0, rxdv = 1'b0;
  logic [1:0]    rel = 2'b00;
  logic          rqrd, wr_en, wr_bank, ovf;
  logic [AW-1:0] wr_addr;
  logic [1:0]    full;
  logic [AW:0]   len0, len1;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  mac_rx_bank_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .mac_clk_i(clk), .ARESETN(arstn), .mac_rxda_i(rxda), .mac_rxsop_i(rxsop),
    .mac_rxeop_i(rxeop), .mac_rxdv_i(rxdv), .mac_rxrqrd_o(rqrd), .wr_en_o(wr_en),
    .wr_bank_o(wr_bank), .wr_addr_o(wr_addr), .rel_i(rel), .bank_full_o(full),
    .bank_len0_o(len0), .bank_len1_o(len1), .pkt_cnt_o(pkt_cnt),
    .drop_cnt_o(drop_cnt), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic          ovf;
  } wr_t;

  wr_t        exp_q[$];
  logic [1:0] pkt_w[$];   // per word: {sop, eop}

  bit m_full[2];
  bit m_last;
  int m_len[2];
  int m_pkt, m_drop;
  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_full[0] = 0; m_full[1] = 0; m_last = 1;
    m_len[0] = 0; m_len[1] = 0; m_pkt = 0; m_drop = 0;
  endfunction

  function automatic int choose_bank();
    if (!m_full[!m_last]) return int'(!m_last);
    if (!m_full[m_last])  return int'(m_last);
    return -1;
  endfunction

  // Packet-level reference: which words land where, and how the packet ends.
  function automatic void model_pkt();
    int b = choose_bank();
    bit seen = 0;
    int a = 0;
    wr_t e;
    if (b < 0) begin m_drop++; return; end
    foreach (pkt_w[i]) begin
      if (pkt_w[i][1]) begin seen = 1; a = 0; end
      if (!seen) continue;
      e.bank = b[0]; e.addr = a[AW-1:0];
      e.ovf  = (!pkt_w[i][0] && a == MAXA);
      exp_q.push_back(e);
      if (e.ovf) begin m_drop++; return; end
      if (pkt_w[i][0]) begin
        m_len[b] = a + 1; m_full[b] = 1; m_pkt++; m_last = b[0];
        return;
      end
      a++;
    end
  endfunction

  function automatic void mk(int n);
    pkt_w.delete();
    for (int i = 0; i < n; i++) pkt_w.push_back({i == 0, i == n - 1});
  endfunction

  function automatic void mk_rand();
    int n = $urandom_range(1, 12);
    int lead = (n > 1 && $urandom_range(0, 5) == 0) ? 1 : 0;
    pkt_w.delete();
    for (int i = 0; i < n; i++) begin
      logic s = (i == lead) || (i > lead && i < n - 1 && $urandom_range(0, 9) == 0);
      pkt_w.push_back({s, i == n - 1});
    end
  endfunction

  task automatic drv(input logic da, input logic dv, input logic sop, input logic eop, input logic [1:0] r);
    @(posedge clk); #1;
    rxda = da; rxdv = dv; rxsop = sop; rxeop = eop; rel = r;
  endtask

  task automatic wait_rqrd();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rqrd) break;
    end
    chk("rqrd_rise", rqrd, 1'b1);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_full"}, full, {m_full[1], m_full[0]});
    chk({tag, "_len0"}, len0, m_len[0]);
    chk({tag, "_len1"}, len1, m_len[1]);
    chk({tag, "_pkt"},  pkt_cnt, m_pkt);
    chk({tag, "_drop"}, drop_cnt, m_drop);
  endtask

  task automatic rel_pulse(input logic [1:0] r);
    drv(0, 0, 0, 0, r);
    drv(0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 2; i++) if (r[i]) m_full[i] = 0;
  endtask

  // Release pulses coincident with the allocation cycle act on pre-release flags.
  task automatic run_pkt(input string tag, input logic [1:0] rel0);
    bit pre_full[2];
    logic prev, da, last;
    pre_full = m_full;
    model_pkt();
    for (int i = 0; i < 2; i++) if (rel0[i] && pre_full[i]) m_full[i] = 0;
    drv(1, 0, 0, 0, rel0);
    wait_rqrd();
    prev = 1'b1;
    foreach (pkt_w[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        da = 1'($urandom_range(0, 1));
        drv(da, 0, 0, 0, 2'b00);
        @(negedge clk); chk("rqrd_follow", rqrd, prev);
        prev = da;
      end
      last = (i == pkt_w.size() - 1);
      drv(!last, 1, pkt_w[i][1], pkt_w[i][0], 2'b00);
      @(negedge clk); chk("rqrd_follow", rqrd, prev);
      prev = !last;
    end
    drv(0, 0, 0, 0, 2'b00);
    @(negedge clk); chk("rqrd_end", rqrd, 1'b0);
    drv(0, 0, 0, 0, 2'b00);
    @(negedge clk);
    check_stats(tag);
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (arstn && wr_en === 1'b1) begin
        if (exp_q.size() == 0) chk("wr_unexpected", wr_en, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("wr_bank", wr_bank, e.bank);
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_ovf", ovf, e.ovf);
        end
      end else if (arstn && ovf === 1'b1) begin
        chk("ovf_no_write", ovf, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b;
    model_reset();
    repeat (3) drv(0, 0, 0, 0, 2'b00);
    arstn = 1'b1;
    @(negedge clk);
    chk("rst_rqrd", rqrd, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_bank", wr_bank, 1'b0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_ovf", ovf, 1'b0);
    check_stats("rst");

    mk(4); run_pkt("p1", 2'b00);
    chk("p1_len0_const", len0, 4);
    mk(2); run_pkt("p2", 2'b00);
    chk("p2_full_const", full, 2'b11);
    mk(3); run_pkt("p3_drop", 2'b00);
    chk("p3_drop_const", drop_cnt, 1);
    rel_pulse(2'b01);
    mk(3); run_pkt("p4_reuse", 2'b00);
    chk("p4_pkt_const", pkt_cnt, 3);
    rel_pulse(2'b11);
    mk(10); run_pkt("p5_ovf", 2'b00);
    chk("p5_full_const", full, 2'b00);
    mk(5); pkt_w[2][1] = 1'b1; run_pkt("p6_restart", 2'b00);
    mk(8); run_pkt("p7_exact", 2'b00);
    chk("p7_len0_const", len0, 8);
    mk(3); run_pkt("p8_same_cycle_rel", 2'b01);
    mk(2); run_pkt("p9_after_rel", 2'b00);

    // Reset in the middle of a packet; the rest of it must be discarded.
    rel_pulse(2'b11);
    b = choose_bank();
    exp_q.push_back('{bank: b[0], addr: AW'(0), ovf: 1'b0});
    exp_q.push_back('{bank: b[0], addr: AW'(1), ovf: 1'b0});
    drv(1, 0, 0, 0, 2'b00);
    wait_rqrd();
    drv(1, 1, 1, 0, 2'b00);
    drv(1, 1, 0, 0, 2'b00);
    @(posedge clk); #1; arstn = 1'b0; rxdv = 1'b0; rxsop = 1'b0;
    @(posedge clk); #1; arstn = 1'b1; rxdv = 1'b1;
    model_reset();
    drv(1, 1, 0, 0, 2'b00);
    drv(0, 1, 0, 1, 2'b00);
    drv(0, 0, 0, 0, 2'b00);
    @(negedge clk);
    check_stats("rst_mid");
    mk(3); run_pkt("p10_clean", 2'b00);
    chk("p10_pkt_const", pkt_cnt, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) rel_pulse(2'($urandom_range(0, 3)));
      mk_rand();
      run_pkt("rnd", 2'b00);
    end

    chk("exp_q_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
